// File: rtl/gcd_binary_param_pkg.sv
// Shared definitions for the binary GCD core: one-hot state encodings and
// the default i_count width helper.
package gcd_pkg;

    localparam logic [3:0] QI    = 4'b0001;
    localparam logic [3:0] QSUB  = 4'b0010;
    localparam logic [3:0] QMULT = 4'b0100;
    localparam logic [3:0] QDONE = 4'b1000;

    typedef enum logic [3:0] {
        ST_I    = QI,
        ST_SUB  = QSUB,
        ST_MULT = QMULT,
        ST_DONE = QDONE
    } state_t;

    // Room for up to WIDTH-1 common factors of two.
    function automatic int gcd_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_binary_param_if.sv
// Start/Ack handshake, operand and result bundle of the binary GCD core.
// Steps exists only when GCD_STEP_COUNT_EN is defined.
interface gcd_binary_param_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = gcd_pkg::gcd_cnt_w(WIDTH)
`ifdef GCD_STEP_COUNT_EN
    , parameter int STEP_W = 8
`endif
);
    logic             SCEN;
    logic             Start;
    logic             Ack;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] AB_GCD;
    logic [CNT_W-1:0] i_count;
    logic             q_I;
    logic             q_Sub;
    logic             q_Mult;
    logic             q_Done;
`ifdef GCD_STEP_COUNT_EN
    logic [STEP_W-1:0] Steps;

    modport master (
        output SCEN, Start, Ack, Ain, Bin,
        input  A, B, AB_GCD, i_count, q_I, q_Sub, q_Mult, q_Done, Steps
    );
    modport slave (
        input  SCEN, Start, Ack, Ain, Bin,
        output A, B, AB_GCD, i_count, q_I, q_Sub, q_Mult, q_Done, Steps
    );
`else
    modport master (
        output SCEN, Start, Ack, Ain, Bin,
        input  A, B, AB_GCD, i_count, q_I, q_Sub, q_Mult, q_Done
    );
    modport slave (
        input  SCEN, Start, Ack, Ain, Bin,
        output A, B, AB_GCD, i_count, q_I, q_Sub, q_Mult, q_Done
    );
`endif
endinterface

// File: rtl/gcd_binary_param_sub_step.sv
// One reduction step of Stein's algorithm: combinational next A/B, a flag to
// count a common factor of two, and a done flag when the odd GCD is found.
module gcd_sub_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic             inc_i,
    output logic             done
);

    // Priority-ordered reduction rules; zero operands terminate immediately.
    always_comb begin
        a_nxt = a;
        b_nxt = b;
        inc_i = 1'b0;
        done  = 1'b0;
        if (a == '0) begin
            done = 1'b1;
        end else if (b == '0) begin
            done = 1'b1;
        end else if (a == b) begin
            done = 1'b1;
        end else if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            inc_i = 1'b1;
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a > b) begin
            a_nxt = a - b;
        end else begin
            b_nxt = b - a;
        end
    end

endmodule

// File: rtl/gcd_binary_param.sv
// Binary (Stein) GCD core with Start/Ack handshake, SCEN single-step gating
// and one-hot state outputs. Optional step counter: GCD_STEP_COUNT_EN.
module gcd_binary_param
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = gcd_cnt_w(WIDTH)
`ifdef GCD_STEP_COUNT_EN
    , parameter int STEP_W = 8
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    gcd_binary_param_if.slave bus
);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [WIDTH-1:0] ab_r, ab_s;
    logic [CNT_W-1:0] icnt_r, icnt_s;
    logic [WIDTH-1:0] step_a_s, step_b_s;
    logic             step_inc_s, step_done_s;
`ifdef GCD_STEP_COUNT_EN
    logic [STEP_W-1:0] steps_r, steps_s;
`endif

    gcd_sub_step #(.WIDTH(WIDTH)) u_sub_step (
        .a     (a_r),
        .b     (b_r),
        .a_nxt (step_a_s),
        .b_nxt (step_b_s),
        .inc_i (step_inc_s),
        .done  (step_done_s)
    );

    // Next-state and next-data; nothing moves unless SCEN is high.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        ab_s    = ab_r;
        icnt_s  = icnt_r;
`ifdef GCD_STEP_COUNT_EN
        steps_s = steps_r;
`endif
        if (bus.SCEN) begin
            case (state_r)
                ST_I: begin
                    if (bus.Start) begin
                        a_s     = bus.Ain;
                        b_s     = bus.Bin;
                        icnt_s  = '0;
`ifdef GCD_STEP_COUNT_EN
                        steps_s = '0;
`endif
                        state_s = ST_SUB;
                    end else begin
                        state_s = ST_I;
                    end
                end
                ST_SUB: begin
`ifdef GCD_STEP_COUNT_EN
                    if (steps_r != '1) begin
                        steps_s = steps_r + STEP_W'(1);
                    end else begin
                        steps_s = steps_r;
                    end
`endif
                    if (step_done_s) begin
                        // Only a zero A selects B; every other exit has the result in A.
                        ab_s    = (a_r == '0) ? b_r : a_r;
                        state_s = ST_MULT;
                    end else begin
                        a_s = step_a_s;
                        b_s = step_b_s;
                        if (step_inc_s) begin
                            icnt_s = icnt_r + CNT_W'(1);
                        end else begin
                            icnt_s = icnt_r;
                        end
                    end
                end
                ST_MULT: begin
                    if (icnt_r == '0) begin
                        state_s = ST_DONE;
                    end else begin
                        ab_s   = ab_r << 1;
                        icnt_s = icnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.Ack) begin
                        state_s = ST_I;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_I;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and data registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_I;
            a_r     <= '0;
            b_r     <= '0;
            ab_r    <= '0;
            icnt_r  <= '0;
`ifdef GCD_STEP_COUNT_EN
            steps_r <= '0;
`endif
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            ab_r    <= ab_s;
            icnt_r  <= icnt_s;
`ifdef GCD_STEP_COUNT_EN
            steps_r <= steps_s;
`endif
        end
    end

    assign bus.A       = a_r;
    assign bus.B       = b_r;
    assign bus.AB_GCD  = ab_r;
    assign bus.i_count = icnt_r;
    assign bus.q_I     = state_r[0];
    assign bus.q_Sub   = state_r[1];
    assign bus.q_Mult  = state_r[2];
    assign bus.q_Done  = state_r[3];
`ifdef GCD_STEP_COUNT_EN
    assign bus.Steps   = steps_r;
`endif

endmodule

// File: tb/tb_gcd_binary_param.sv
// Directed bench for gcd_binary_param: 8-bit and 16-bit instances, hand-computed
// latencies and results, SCEN gating, handshake corner cases and async reset.
module tb_gcd_binary_param;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    gcd_binary_param_if #(.WIDTH(8))  bus8 ();
    gcd_binary_param_if #(.WIDTH(16)) bus16 ();

    gcd_binary_param #(.WIDTH(8))  dut8  (.Clk(Clk), .Reset(Reset), .bus(bus8.slave));
    gcd_binary_param #(.WIDTH(16)) dut16 (.Clk(Clk), .Reset(Reset), .bus(bus16.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start a run on the 8-bit core and follow it to q_Done, optionally gating SCEN 1,0,0,1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit toggle,
                        output int en_edges, output int sub_cyc, output int icmax,
                        output logic [7:0] ab_mult, output int hold_err);
        logic [31:0] snap;
        logic        was_sub;
        logic        scen;
`ifdef GCD_STEP_COUNT_EN
        logic [7:0]  snap_steps;
`endif
        bus8.Ain   = a;
        bus8.Bin   = b;
        bus8.SCEN  = 1'b1;
        bus8.Start = 1'b1;
        step();
        bus8.Start = 1'b0;
        en_edges = 1;
        sub_cyc  = 0;
        icmax    = 0;
        ab_mult  = 8'd0;
        hold_err = 0;
        for (int k = 0; k < 200 && !bus8.q_Done; k++) begin
            scen = toggle ? (((k + 1) % 4 == 0) || ((k + 1) % 4 == 3)) : 1'b1;
            bus8.SCEN = scen;
            was_sub = bus8.q_Sub;
            snap = {bus8.A, bus8.B, bus8.AB_GCD, bus8.i_count,
                    bus8.q_I, bus8.q_Sub, bus8.q_Mult, bus8.q_Done};
`ifdef GCD_STEP_COUNT_EN
            snap_steps = bus8.Steps;
`endif
            step();
            if (scen) begin
                en_edges++;
                if (was_sub) sub_cyc++;
                if (was_sub && bus8.q_Mult) ab_mult = bus8.AB_GCD;
                if (int'(bus8.i_count) > icmax) icmax = int'(bus8.i_count);
            end else begin
                if (snap != {bus8.A, bus8.B, bus8.AB_GCD, bus8.i_count,
                             bus8.q_I, bus8.q_Sub, bus8.q_Mult, bus8.q_Done}) hold_err++;
`ifdef GCD_STEP_COUNT_EN
                if (snap_steps != bus8.Steps) hold_err++;
`endif
            end
        end
        bus8.SCEN = 1'b1;
        if (!bus8.q_Done) en_edges = -1;
    endtask

    initial begin
        int         edges, subc, imax, herr;
        logic [7:0] abm;

        Reset = 1'b1;
        bus8.SCEN  = 1'b1; bus8.Start  = 1'b0; bus8.Ack  = 1'b0; bus8.Ain  = 8'd0;  bus8.Bin  = 8'd0;
        bus16.SCEN = 1'b1; bus16.Start = 1'b0; bus16.Ack = 1'b0; bus16.Ain = 16'd0; bus16.Bin = 16'd0;
        #2;
        chk("rst_qI", bus8.q_I, 1);
        chk("rst_qSub", bus8.q_Sub, 0);
        chk("rst_A", bus8.A, 0);
        chk("rst_AB", bus8.AB_GCD, 0);
        chk("rst_icnt", bus8.i_count, 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // 36/24: six sub cycles, odd GCD 3, two doublings -> 12.
        run8(8'd36, 8'd24, 1'b0, edges, subc, imax, abm, herr);
        chk("g36_edges", edges, 10);
        chk("g36_subcyc", subc, 6);
        chk("g36_ab_at_mult", abm, 3);
        chk("g36_icmax", imax, 2);
        chk("g36_ab", bus8.AB_GCD, 12);
        chk("g36_icnt", bus8.i_count, 0);
        chk("g36_onehot", {bus8.q_I, bus8.q_Sub, bus8.q_Mult, bus8.q_Done}, 4'b0001);
`ifdef GCD_STEP_COUNT_EN
        chk("g36_steps", bus8.Steps, 6);
`endif
        bus8.Start = 1'b1;
        step();
        chk("start_in_done_ignored", bus8.q_Done, 1);
        bus8.Start = 1'b0;
        bus8.Ack = 1'b1;
        step();
        chk("ack_to_qI", bus8.q_I, 1);
        chk("ab_hold_after_ack", bus8.AB_GCD, 12);
        step();
        chk("ack_in_qI_noeffect", bus8.q_I, 1);
        bus8.Ack = 1'b0;

        run8(8'd5, 8'd15, 1'b0, edges, subc, imax, abm, herr);
        chk("g5_edges", edges, 5);
        chk("g5_subcyc", subc, 3);
        chk("g5_ab", bus8.AB_GCD, 5);
        chk("g5_icnt", bus8.i_count, 0);
`ifdef GCD_STEP_COUNT_EN
        chk("g5_steps", bus8.Steps, 3);
`endif
        bus8.Start = 1'b1;
        bus8.Ack = 1'b1;
        step();
        chk("start_ack_ack_wins", bus8.q_I, 1);
        bus8.Start = 1'b0;
        bus8.Ack = 1'b0;
        step();
        chk("start_not_latched", bus8.q_I, 1);

        run8(8'd0, 8'd20, 1'b0, edges, subc, imax, abm, herr);
        chk("z20_subcyc", subc, 1);
        chk("z20_edges", edges, 3);
        chk("z20_ab", bus8.AB_GCD, 20);
        bus8.Ack = 1'b1; step(); bus8.Ack = 1'b0;

        run8(8'd0, 8'd0, 1'b0, edges, subc, imax, abm, herr);
        chk("z0_subcyc", subc, 1);
        chk("z0_ab", bus8.AB_GCD, 0);
        bus8.Ack = 1'b1; step(); bus8.Ack = 1'b0;

        // Same 36/24 run with SCEN gated: only enabled edges count.
        run8(8'd36, 8'd24, 1'b1, edges, subc, imax, abm, herr);
        chk("scen_hold_errs", herr, 0);
        chk("scen_en_edges", edges, 10);
        chk("scen_ab", bus8.AB_GCD, 12);
`ifdef GCD_STEP_COUNT_EN
        chk("scen_steps", bus8.Steps, 6);
`endif
        bus8.Ack = 1'b1; step(); bus8.Ack = 1'b0;

        // 16-bit: 65280/4080 -> four common twos, odd part 255, 15 edges total.
        bus16.Ain = 16'd65280;
        bus16.Bin = 16'd4080;
        bus16.Start = 1'b1;
        step();
        bus16.Start = 1'b0;
        edges = 1;
        imax = 0;
        for (int k = 0; k < 200 && !bus16.q_Done; k++) begin
            step();
            edges++;
            if (int'(bus16.i_count) > imax) imax = int'(bus16.i_count);
        end
        if (!bus16.q_Done) edges = -1;
        chk("w16_edges", edges, 15);
        chk("w16_ab", bus16.AB_GCD, 4080);
        chk("w16_icmax", imax, 4);

        // Async reset while in q_Sub with partial state.
        bus8.Ain = 8'd36;
        bus8.Bin = 8'd24;
        bus8.Start = 1'b1;
        step();
        bus8.Start = 1'b0;
        step();
        chk("mid_pre_icnt", bus8.i_count, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_qI", bus8.q_I, 1);
        chk("mid_rst_qSub", bus8.q_Sub, 0);
        chk("mid_rst_A", bus8.A, 0);
        chk("mid_rst_B", bus8.B, 0);
        chk("mid_rst_icnt", bus8.i_count, 0);
        chk("mid_rst_AB", bus8.AB_GCD, 0);
        Reset = 1'b0;
        run8(8'd5, 8'd15, 1'b0, edges, subc, imax, abm, herr);
        chk("post_rst_edges", edges, 5);
        chk("post_rst_ab", bus8.AB_GCD, 5);
        bus8.Ack = 1'b1; step(); bus8.Ack = 1'b0;
        chk("post_rst_ack", bus8.q_I, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_binary_param.md
# gcd_binary_param

Parametrised successor to the 8-bit GCD core: computes GCD(Ain, Bin) for WIDTH-bit unsigned operands using the binary (Stein) algorithm. The core factors out common powers of two, then subtracts and shifts, then restores those powers in a multiply phase. It keeps the established Start/Ack handshake, SCEN single-step gating and one-hot state outputs, so it drops into the existing top-level and single-step harness. It adds correct zero-operand handling and an optional step counter.

## Interface
- WIDTH, 8: operand/result width, ≥ 2
- CNT_W, $clog2(WIDTH)+1: width of i_count
- STEP_W, 8: width of Steps; only used with the step counter
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- SCEN  in  1  single-clock enable; all state/data updates happen only when 1
- Start  in  1  begin computation, sampled in q_I
- Ack  in  1  acknowledge result, sampled in q_Done
- Ain, Bin  in  WIDTH  operands, sampled in q_I on Start
- A, B  out  WIDTH  working registers
- AB_GCD  out  WIDTH  result register
- i_count  out  CNT_W  count of common factors of two
- q_I, q_Sub, q_Mult, q_Done  out  1 each  one-hot state
- Steps  out  STEP_W  q_Sub cycles of the last run; only with GCD_STEP_COUNT_EN

## Operation
- Reset value: state q_I; A, B, AB_GCD, i_count and Steps are 0.
- All of the following act only on a Clk edge with SCEN=1. With SCEN=0 every register holds.
- q_I: on Start, load A←Ain, B←Bin, i_count←0, Steps←0, then go to q_Sub. Otherwise stay.
- q_Sub: first matching rule wins.
  1. A==0: AB_GCD←B, go to q_Mult.
  2. B==0: AB_GCD←A, go to q_Mult.
  3. A==B: AB_GCD←A, go to q_Mult.
  4. Both even: A←A>>1, B←B>>1, i_count+1.
  5. A even: A←A>>1.
  6. B even: B←B>>1.
  7. Both odd: the larger operand ← larger − smaller.
  - Steps+1 on every q_Sub cycle, saturating at all-ones.
- q_Mult: if i_count==0, go to q_Done. Else AB_GCD←AB_GCD<<1 and i_count−1.
- q_Done: on Ack, go to q_I. AB_GCD, A, B and Steps hold until the next Start.
- Arithmetic and width rules:
  - All arithmetic is unsigned.
  - Subtraction never underflows (larger − smaller).
  - i_count ≤ WIDTH−1.
  - The final AB_GCD ≤ max(Ain,Bin), so no overflow.
- GCD(0,0)=0; GCD(0,x)=x.

## Timing
- Start sampled in q_I → q_Sub on the next edge.
- Total latency is 1 + (q_Sub cycles) + (i_count_max + 1) enabled edges from the Start-sampling edge to q_Done.
- Start outside q_I is ignored. Ack outside q_Done is ignored.
- Start and Ack both high in q_Done: Ack wins and the core goes to q_I. Start is honoured only on a later q_I cycle.
- Ack held high across q_I has no effect.
- Reset mid-computation asynchronously forces the reset values listed above; no partial result is kept.
- Outputs are registered and valid one edge after each transition.

## Configuration
- GCD_STEP_COUNT_EN defined: the Steps port and register exist; behaviour is as above.
- GCD_STEP_COUNT_EN undefined: there is no Steps port and no counter logic; all other behaviour is identical.

## Structure
- Package gcd_pkg holds the one-hot state localparams QI, QSUB, QMULT, QDONE (4-bit) and a function computing the default CNT_W from WIDTH.
- Sub-module gcd_sub_step: purely combinational. It takes A and B and returns next A, next B, inc_i and a done flag. The q_Sub rules live there; the top holds the FSM and registers.

## Test plan
- WIDTH=8, Ain=36, Bin=24, SCEN=1:
  - 6 q_Sub cycles, then AB_GCD=3, then i_count 2 and 2 q_Mult shifts.
  - Expected result: q_Done 10 edges after the Start edge, AB_GCD=12, Steps=6.
- WIDTH=8, Ain=5, Bin=15: q_Done after 5 edges, AB_GCD=5, i_count=0, Steps=3. Ack returns the core to q_I.
- Zero operands, Ain=0 with Bin=20 and Ain=0 with Bin=0: AB_GCD=20 and 0 respectively. q_Sub lasts exactly 1 cycle.
- SCEN toggling 1,0,0,1 during the 36/24 run:
  - No register changes on SCEN=0 edges.
  - Final result and Steps match the SCEN=1 run.
- WIDTH=16, Ain=65280, Bin=4080 (GCD 4080): AB_GCD=4080, i_count peaks at 4.
- Reset asserted in q_Sub between edges: all outputs immediately return to the reset values. A new Start/Ack pair then works normally.
